// File: rtl/array_div_seq_if.sv
// array_div_seq_if: start/done handshake and operand/result bus of the
// sequential restoring divider.
//   master: drives start, dividend, divisor; observes busy/done and results.
//   slave : the divider side.
interface array_div_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          chk_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, chk_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, chk_err
  );
endinterface

// File: rtl/array_div_seq.sv
// array_div_seq: sequential unsigned restoring divider, DW-bit dividend by
// VW-bit divisor, one quotient bit per clock behind a start/done handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - array_div_seq_if.slave: start/dividend/divisor in;
//          busy/done/quotient/remainder/div_by_zero/chk_err out (registered)
// Optional feature: define DIV_SELF_CHECK_EN to reconstruct
// quotient*divisor+remainder at completion and flag a mismatch on chk_err.
// Without it chk_err is held at 0 and no multiplier exists.
module array_div_seq (
  input logic           clk,
  input logic           rst,
  array_div_seq_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned RW = VW + 1;
  localparam int unsigned CW = $clog2(DW);
`ifdef DIV_SELF_CHECK_EN
  localparam int unsigned PW = DW + VW;
  localparam int unsigned AW = DW;
`else
  localparam int unsigned AW = VW;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] rem_q, rem_d;     // partial remainder, always < divisor between steps
  logic [DW-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [AW-1:0] a_q, a_d;         // captured dividend (low bits only unless self-check)
  logic [VW-1:0] v_q, v_d;         // captured divisor
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dbz_q, dbz_d;
  logic          chk_q, chk_d;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] diff;
  logic          neg;
  logic [DW-1:0] quot_res;
  logic [VW-1:0] rem_res;
  logic          dbz_res;
`ifdef DIV_SELF_CHECK_EN
  logic [PW-1:0] recon;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      a_q     <= '0;
      v_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      a_q     <= a_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      chk_q   <= chk_d;
    end
  end

  // Restoring step and final result selection
  always_comb begin
    rem_sh = {rem_q, dvd_q[DW-1]};
    diff   = rem_sh - {1'b0, v_q};
    // rem_sh <= 2*divisor-1, so the sign bit of the VW+1-bit difference is exact
    neg    = diff[RW-1];

    dbz_res  = (v_q == '0);
    quot_res = dbz_res ? {DW{1'b1}} : dvd_q;
    rem_res  = dbz_res ? a_q[VW-1:0] : rem_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    a_d     = a_q;
    v_d     = v_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    chk_d   = chk_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = AW'(bus.dividend);
          v_d     = bus.divisor;
          dvd_d   = bus.dividend;
          rem_d   = '0;
          cnt_d   = CW'(DW - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        dvd_d = {dvd_q[DW-2:0], ~neg};
        rem_d = neg ? rem_sh[VW-1:0] : diff[VW-1:0];
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        quot_d = quot_res;
        remo_d = rem_res;
        dbz_d  = dbz_res;
`ifdef DIV_SELF_CHECK_EN
        chk_d  = !dbz_res && (recon != PW'(a_q));
`else
        chk_d  = 1'b0;
`endif
        state_d = IDLE;
        if (bus.start) begin
          a_d     = AW'(bus.dividend);
          v_d     = bus.divisor;
          dvd_d   = bus.dividend;
          rem_d   = '0;
          cnt_d   = CW'(DW - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_SELF_CHECK_EN
  // Reconstruct the dividend from the results for the completion check
  always_comb begin
    recon = PW'(quot_res) * PW'(v_q) + PW'(rem_res);
  end
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.chk_err     = chk_q;
endmodule

// File: tb/tb_array_div_seq.sv
// tb_array_div_seq: scoreboard bench for array_div_seq. Stimulus pushes the
// expected result (from plain integer division) and its due cycle; a monitor
// at each falling edge checks busy, the done timing and the results.
module tb_array_div_seq;
  logic clk;
  logic rst;

  array_div_seq_if bus ();

  array_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int q;
    int r;
    int z;
    int st;
    int due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  int   perm[4096];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, ncyc);
    end
  endfunction

  // Monitor: one sample per falling edge
  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    ncyc++;
    if (!rst) begin
      eb = (sb.size() > 0) && (sb[0].st <= ncyc) && (ncyc < sb[0].due);
      chk("busy", int'(bus.busy), int'(eb));
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", ncyc, e.due);
          chk("quotient", int'(bus.quotient), e.q);
          chk("remainder", int'(bus.remainder), e.r);
          chk("div_by_zero", int'(bus.div_by_zero), e.z);
          chk("chk_err", int'(bus.chk_err), 0);
        end
      end else if (sb.size() > 0 && ncyc >= sb[0].due) begin
        chk("missing_done", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Reference: plain unsigned division, divisor 0 per the forced-result rule
  task automatic push_exp(input int a, input int b);
    exp_t e;
    e.z   = (b == 0) ? 1 : 0;
    e.q   = (b == 0) ? 255 : a / b;
    e.r   = (b == 0) ? a % 16 : a % b;
    e.st  = ncyc + 1;
    e.due = ncyc + 1 + 9;
    sb.push_back(e);
  endtask

  // Wait (bounded) for an idle or done cycle, then present one start pulse
  task automatic issue(input int a, input int b);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("issue_timeout", 1, 0);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    @(posedge clk);
    push_exp(a, b);
    #1 bus.start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_quot"}, int'(bus.quotient), 0);
    chk({tag, "_rem"}, int'(bus.remainder), 0);
    chk({tag, "_dbz"}, int'(bus.div_by_zero), 0);
    chk({tag, "_chk"}, int'(bus.chk_err), 0);
  endtask

  initial begin
    int n;
    int j;
    int t;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Directed cases
    issue(200, 7);
    issue(255, 1);
    issue(13, 15);
    issue(100, 0);

    // Second start during RUN is ignored; follow-up issued in the done cycle
    issue(50, 5);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = 8'd90; bus.divisor = 4'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignored_start_done", int'(bus.done), 1);
    bus.start = 1'b1; bus.dividend = 8'd90; bus.divisor = 4'd9;
    @(posedge clk);
    push_exp(90, 9);
    #1 bus.start = 1'b0;

    // Reset in the middle of RUN discards the operation
    issue(143, 11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check_outputs_zero("midrun_reset");
    rst = 1'b0;
    issue(143, 11);

    // Every operand pair once, in random order, with occasional idle gaps
    for (int i = 0; i < 4096; i++) perm[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      issue(perm[i] >> 4, perm[i] & 15);
    end

    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
